// File: rtl/fft_bfly_sched_if.sv
// Issue/write-back bus between the FFT butterfly sequencer and its host/datapath.
interface fft_bfly_sched_if #(parameter int N_LOG2 = 4);
  logic              start, stall;
  logic              busy, done;
  logic [N_LOG2-1:0] stage;
  logic              rd_valid;
  logic [N_LOG2-1:0] rd_addr_a, rd_addr_b;
  logic [N_LOG2-2:0] tw_idx;
  logic              wr_valid;
  logic [N_LOG2-1:0] wr_addr_a, wr_addr_b;

  modport master (output start, stall,
                  input  busy, done, stage, rd_valid, rd_addr_a, rd_addr_b,
                         tw_idx, wr_valid, wr_addr_a, wr_addr_b);
  modport slave  (input  start, stall,
                  output busy, done, stage, rd_valid, rd_addr_a, rd_addr_b,
                         tw_idx, wr_valid, wr_addr_a, wr_addr_b);
endinterface

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIF FFT sequencer: one butterfly issue per cycle, write-back
// addresses delayed by the datapath latency, drain between stages.
module fft_bfly_sched #(
  parameter int N_LOG2   = 4,
  parameter int PIPE_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  fft_bfly_sched_if.slave bus
);
  localparam int W = N_LOG2;
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] LAST  = W'(N_LOG2 - 1);
  localparam logic [W-2:0] JLAST = '1;
  localparam logic [3:0]   DLAST = 4'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  stage;
  logic [W-2:0]  j;
  logic [3:0]    dcnt;
  logic          busy, done;
  logic          rd_valid;
  logic [W-1:0]  p, hmask, jw, a_n, b_n;
  logic [W-2:0]  kk, tw_n;

  logic [PIPE_LAT:1]        vld_pipe;
  logic [PIPE_LAT:1][W-1:0] a_pipe, b_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      j     <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          stage <= '0;
          j     <= '0;
          busy  <= 1'b1;
        end
        RUN: if (!bus.stall) begin
          if (j == JLAST) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            j <= j + 1'b1;
          end
        end
        // Hold off the next stage until the last write-back has left the pipe.
        DRAIN: if (dcnt == DLAST) begin
          if (stage == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RUN;
            stage <= stage + 1'b1;
            j     <= '0;
          end
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_valid = (state == RUN) && !bus.stall;

  // Pair address = j with a zero bit inserted at position N_LOG2-1-stage.
  always_comb begin
    p     = LAST - stage;
    hmask = (ONE << p) - ONE;
    jw    = {1'b0, j};
    a_n   = ((jw & ~hmask) << 1) | (jw & hmask);
    b_n   = a_n | (ONE << p);
    kk    = j & hmask[W-2:0];
    tw_n  = kk << stage;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      for (int i = PIPE_LAT; i > 1; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        a_pipe[i]   <= a_pipe[i-1];
        b_pipe[i]   <= b_pipe[i-1];
      end
      vld_pipe[1] <= rd_valid;
      a_pipe[1]   <= bus.rd_addr_a;
      b_pipe[1]   <= bus.rd_addr_b;
    end
  end

  // Addresses are forced to zero when idle so the bus reads all-zero out of reset.
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_addr_a = rd_valid ? a_n  : '0;
  assign bus.rd_addr_b = rd_valid ? b_n  : '0;
  assign bus.tw_idx    = rd_valid ? tw_n : '0;
  assign bus.wr_valid  = vld_pipe[PIPE_LAT];
  assign bus.wr_addr_a = a_pipe[PIPE_LAT];
  assign bus.wr_addr_b = b_pipe[PIPE_LAT];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.stage     = stage;
endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed-vector bench for fft_bfly_sched: PIPE_LAT=1 and PIPE_LAT=3 instances, N=16.
module tb_fft_bfly_sched;
  typedef struct {int a; int b; int tw;} vec_t;
  typedef struct packed {int cyc; logic [3:0] st; logic [3:0] a; logic [3:0] b; logic [2:0] tw;} rec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  vec_t vt[32];

  rec_t iss1[$], wr1[$], iss3[$], wr3[$];
  int   brise1[$], done1[$], brise3[$], done3[$];
  logic pb1 = 1'b0, pb3 = 1'b0;

  fft_bfly_sched_if #(.N_LOG2(4)) b1();
  fft_bfly_sched_if #(.N_LOG2(4)) b3();

  fft_bfly_sched #(.N_LOG2(4), .PIPE_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  fft_bfly_sched #(.N_LOG2(4), .PIPE_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b1.rd_valid) iss1.push_back('{cyc, b1.stage, b1.rd_addr_a, b1.rd_addr_b, b1.tw_idx});
    if (b1.wr_valid) wr1.push_back('{cyc, 4'd0, b1.wr_addr_a, b1.wr_addr_b, 3'd0});
    if (b1.busy && !pb1) brise1.push_back(cyc);
    if (b1.done) done1.push_back(cyc);
    pb1 <= b1.busy;
  end

  always @(negedge clk) begin
    if (b3.rd_valid) iss3.push_back('{cyc, b3.stage, b3.rd_addr_a, b3.rd_addr_b, b3.tw_idx});
    if (b3.wr_valid) wr3.push_back('{cyc, 4'd0, b3.wr_addr_a, b3.wr_addr_b, 3'd0});
    if (b3.busy && !pb3) brise3.push_back(cyc);
    if (b3.done) done3.push_back(cyc);
    pb3 <= b3.busy;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Compare one full transform's issue/write-back log against the vector table.
  task automatic check_run(input string tag, input rec_t iq[$], input rec_t wq[$],
                           input int ib, input int wb, input int lat);
    chk({tag, "_rd_count"}, iq.size() - ib, 32);
    chk({tag, "_wr_count"}, wq.size() - wb, 32);
    for (int i = 0; i < 32; i++) begin
      if (ib + i < iq.size())
        chk($sformatf("%s_rd%0d", tag, i),
            int'({iq[ib+i].st, iq[ib+i].a, iq[ib+i].b, iq[ib+i].tw}),
            int'({4'(i / 8), 4'(vt[i].a), 4'(vt[i].b), 3'(vt[i].tw)}));
      if (ib + i < iq.size() && wb + i < wq.size())
        chk($sformatf("%s_wr%0d", tag, i),
            int'({wq[wb+i].a, wq[wb+i].b, 8'(wq[wb+i].cyc - iq[ib+i].cyc)}),
            int'({4'(vt[i].a), 4'(vt[i].b), 8'(lat)}));
    end
    for (int s = 0; s < 3; s++)
      if (ib + 8*(s+1) < iq.size() && wb + 8*s + 7 < wq.size())
        chk($sformatf("%s_order%0d", tag, s),
            int'(iq[ib+8*(s+1)].cyc > wq[wb+8*s+7].cyc), 1);
  endtask

  task automatic wait_done1(input int db);
    for (int i = 0; i < 200 && done1.size() == db; i++) @(posedge clk);
    chk("done1_seen", int'(done1.size() > db), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int ib, wb, bb, db;
    rst = 1'b1;
    b1.start = 1'b0; b1.stall = 1'b0;
    b3.start = 1'b0; b3.stall = 1'b0;

    vt[0]='{0,8,0};   vt[1]='{1,9,1};   vt[2]='{2,10,2};  vt[3]='{3,11,3};
    vt[4]='{4,12,4};  vt[5]='{5,13,5};  vt[6]='{6,14,6};  vt[7]='{7,15,7};
    vt[8]='{0,4,0};   vt[9]='{1,5,2};   vt[10]='{2,6,4};  vt[11]='{3,7,6};
    vt[12]='{8,12,0}; vt[13]='{9,13,2}; vt[14]='{10,14,4}; vt[15]='{11,15,6};
    vt[16]='{0,2,0};  vt[17]='{1,3,4};  vt[18]='{4,6,0};  vt[19]='{5,7,4};
    vt[20]='{8,10,0}; vt[21]='{9,11,4}; vt[22]='{12,14,0}; vt[23]='{13,15,4};
    vt[24]='{0,1,0};  vt[25]='{2,3,0};  vt[26]='{4,5,0};  vt[27]='{6,7,0};
    vt[28]='{8,9,0};  vt[29]='{10,11,0}; vt[30]='{12,13,0}; vt[31]='{14,15,0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs1", int'({b1.busy, b1.done, b1.rd_valid, b1.wr_valid, b1.stage, b1.rd_addr_a,
                             b1.rd_addr_b, b1.tw_idx, b1.wr_addr_a, b1.wr_addr_b}), 0);
    chk("reset_outs3", int'({b3.busy, b3.done, b3.rd_valid, b3.wr_valid, b3.stage, b3.rd_addr_a,
                             b3.rd_addr_b, b3.tw_idx, b3.wr_addr_a, b3.wr_addr_b}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unstalled full transform, PIPE_LAT=1.
    ib = iss1.size(); wb = wr1.size(); bb = brise1.size(); db = done1.size();
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    wait_done1(db);
    check_run("run", iss1, wr1, ib, wb, 1);
    chk("run_done_cnt", done1.size() - db, 1);
    chk("run_busy_dur", (done1.size() > db && brise1.size() > bb) ? done1[db] - brise1[bb] : -1, 36);
    chk("run_first_issue", (iss1.size() > ib && brise1.size() > bb) ? iss1[ib].cyc - brise1[bb] : -1, 0);

    // Start with stall in IDLE (start wins), then a 3-cycle stall after the 3rd issue.
    ib = iss1.size(); wb = wr1.size(); bb = brise1.size(); db = done1.size();
    b1.start = 1'b1; b1.stall = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0; b1.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    b1.stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b1.stall = 1'b0;
    wait_done1(db);
    check_run("stall", iss1, wr1, ib, wb, 1);
    chk("stall_rd_gap", iss1.size() > ib + 3 ? iss1[ib+3].cyc - iss1[ib+2].cyc : -1, 4);
    chk("stall_wr_gap", wr1.size() > wb + 3 ? wr1[wb+3].cyc - wr1[wb+2].cyc : -1, 4);
    chk("stall_busy_dur", (done1.size() > db && brise1.size() > bb) ? done1[db] - brise1[bb] : -1, 39);

    // Reset in the middle of stage 2 aborts with no done.
    db = done1.size();
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    for (int i = 0; i < 100 && b1.stage != 4'd2; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_reach_stage2", int'(b1.stage), 2);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_outs_zero", int'({b1.busy, b1.done, b1.rd_valid, b1.wr_valid, b1.stage, b1.rd_addr_a,
                                 b1.rd_addr_b, b1.tw_idx, b1.wr_addr_a, b1.wr_addr_b}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done1.size() - db, 0);
    chk("abort_idle", int'({b1.busy, b1.rd_valid}), 0);

    // Restart after abort; a second start while busy must not disturb the run.
    ib = iss1.size(); wb = wr1.size(); bb = brise1.size(); db = done1.size();
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    wait_done1(db);
    check_run("restart", iss1, wr1, ib, wb, 1);
    chk("restart_done_cnt", done1.size() - db, 1);
    chk("restart_busy_dur", (done1.size() > db && brise1.size() > bb) ? done1[db] - brise1[bb] : -1, 36);

    // PIPE_LAT=3 instance: 3-cycle drains, 44-cycle busy window.
    ib = iss3.size(); wb = wr3.size(); bb = brise3.size(); db = done3.size();
    b3.start = 1'b1;
    @(posedge clk); #1;
    b3.start = 1'b0;
    for (int i = 0; i < 200 && done3.size() == db; i++) @(posedge clk);
    chk("lat3_done_seen", int'(done3.size() > db), 1);
    repeat (2) @(posedge clk);
    #1;
    check_run("lat3", iss3, wr3, ib, wb, 3);
    chk("lat3_busy_dur", (done3.size() > db && brise3.size() > bb) ? done3[db] - brise3[bb] : -1, 44);
    for (int s = 0; s < 3; s++)
      chk($sformatf("lat3_drain%0d", s),
          iss3.size() > ib + 8*(s+1) ? iss3[ib+8*(s+1)].cyc - iss3[ib+8*s+7].cyc : -1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
